// File: rtl/cost_func_unit_pkg.sv
// cost_func_unit_pkg: Q6.11 format, PLAN sigmoid constants and FSM encoding shared by the cost unit
package cost_func_unit_pkg;
   localparam int QN = 6;
   localparam int QM = 11;
   localparam int BITWIDTH = QN + QM + 1;
   localparam logic [QM:0] ONE_Q = {1'b1, {QM{1'b0}}};
   // PLAN breakpoints on |x|, Q6.11
   localparam logic [BITWIDTH-1:0] BP_HI = BITWIDTH'(5 << QM);
   localparam logic [BITWIDTH-1:0] BP_MID = BITWIDTH'((19 << QM) / 8);
   localparam logic [BITWIDTH-1:0] BP_LO = BITWIDTH'(1 << QM);
   // PLAN segment offsets, Q0.11
   localparam logic [QM:0] OFF_HI = (QM+1)'((27 << QM) / 32);
   localparam logic [QM:0] OFF_MID = (QM+1)'((5 << QM) / 8);
   localparam logic [QM:0] OFF_LO = (QM+1)'(1 << (QM - 1));
   typedef enum logic [2:0] {IDLE, SIG, ERR, SQR, OUT} costState_t;
endpackage

// File: rtl/cost_func_unit_sigmoid_plan.sv
// sigmoid_plan: combinational shift-and-add piecewise-linear sigmoid
//   x     in  signed Q6.11 argument
//   sigma out unsigned Q0.11 result, 0..2048
module sigmoid_plan
   import cost_func_unit_pkg::*;
(
   input  logic signed [BITWIDTH-1:0] x,
   output logic [QM:0] sigma
);
   logic [BITWIDTH-1:0] a;
   logic [QM:0] y;
   always_comb begin
      // the most negative x negates to 2^17, still representable unsigned and lands in the saturated region
      a = x[BITWIDTH-1] ? -$unsigned(x) : $unsigned(x);
      y = a >= BP_HI  ? ONE_Q :
          a >= BP_MID ? (QM+1)'((a >> 5) + BITWIDTH'(OFF_HI)) :
          a >= BP_LO  ? (QM+1)'((a >> 3) + BITWIDTH'(OFF_MID)) :
                        (QM+1)'((a >> 2) + BITWIDTH'(OFF_LO));
      sigma = x[BITWIDTH-1] ? ONE_Q - y : y;
   end
endmodule

// File: rtl/cost_func_unit.sv
// cost_func_unit: squared-error cost of the perceptron output against a 1-bit label
//   clock, reset      rising-edge clock, synchronous active-low reset
//   dataReadyP        perceptron ready level; its rising edge starts a computation
//   networkOutput     signed Q6.11 perceptron output, modelOutput 1-bit target
//   newCostFunc       one-cycle pulse, costFunc valid (4 cycles after the trigger)
//   costFunc          unsigned Q6.11 squared error, 0..2048, held until the next result
//   busy, overrun     computation in flight; sticky trigger-while-busy flag
//   statClear, wrongCount  misclassification counter, only with COST_STATS_EN defined
module cost_func_unit
   import cost_func_unit_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic dataReadyP,
   input  logic signed [BITWIDTH-1:0] networkOutput,
   input  logic modelOutput,
   output logic newCostFunc,
   output logic [BITWIDTH-1:0] costFunc,
   output logic busy,
   output logic overrun
`ifdef COST_STATS_EN
   ,
   input  logic statClear,
   output logic [15:0] wrongCount
`endif
);
   costState_t state, nextState;
   logic prevReady, trigger, modelQ;
   logic signed [BITWIDTH-1:0] xQ;
   logic [QM:0] sigmaComb, sigmaQ;
   logic signed [QM+1:0] errQ;
   logic signed [2*QM+3:0] prod;
   logic [2*QM+3:0] rounded;
   logic [BITWIDTH-1:0] costNext;

   sigmoid_plan plan (.x(xQ), .sigma(sigmaComb));

   always_comb begin
      trigger = dataReadyP && !prevReady;
      nextState = state == IDLE ? (trigger ? SIG : IDLE) :
                  state == SIG  ? ERR :
                  state == ERR  ? SQR :
                  state == SQR  ? OUT : IDLE;
      // square and round in the SQR cycle so the result is registered for the OUT cycle
      prod = errQ * errQ;
      rounded = ($unsigned(prod) + (2*QM+4)'(OFF_LO)) >> QM;
      costNext = rounded > (2*QM+4)'(ONE_Q) ? BITWIDTH'(ONE_Q) : BITWIDTH'(rounded);
      newCostFunc = state == OUT;
      busy = state != IDLE;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         prevReady <= 1'b0;
         costFunc <= '0;
         overrun <= 1'b0;
      end else begin
         state <= nextState;
         prevReady <= dataReadyP;
         if (state == SQR) costFunc <= costNext;
         if (trigger && state != IDLE) overrun <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (state == IDLE && trigger) begin
         xQ <= networkOutput;
         modelQ <= modelOutput;
      end
      if (state == SIG) sigmaQ <= sigmaComb;
      if (state == ERR) errQ <= $signed({1'b0, modelQ ? ONE_Q : '0}) - $signed({1'b0, sigmaQ});
   end

`ifdef COST_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset || statClear) wrongCount <= '0;
      else if (state == OUT && (sigmaQ >= OFF_LO) != modelQ && wrongCount != 16'hFFFF)
         wrongCount <= wrongCount + 16'd1;
   end
`endif
endmodule

// File: tb/tb_cost_func_unit.sv
// tb_cost_func_unit: directed-vector self-checking bench for cost_func_unit
module tb_cost_func_unit;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic dataReadyP = 1'b0;
   logic signed [17:0] networkOutput = '0;
   logic modelOutput = 1'b0;
   logic newCostFunc, busy, overrun;
   logic [17:0] costFunc;
   int vectors = 0;
   int miscompares = 0;
`ifdef COST_STATS_EN
   logic statClear = 1'b0;
   logic [15:0] wrongCount;
   bit clrAtOut = 1'b0;
`endif

   always #5 clock = ~clock;

   cost_func_unit dut (
      .clock(clock), .reset(reset), .dataReadyP(dataReadyP),
      .networkOutput(networkOutput), .modelOutput(modelOutput),
      .newCostFunc(newCostFunc), .costFunc(costFunc), .busy(busy), .overrun(overrun)
`ifdef COST_STATS_EN
      , .statClear(statClear), .wrongCount(wrongCount)
`endif
   );

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic runVec(input string tag, input int x, input bit m, input int expCost);
      int pulses = 0;
      int pulseAt = 0;
      tick();
      networkOutput = 18'(x);
      modelOutput = m;
      dataReadyP = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         dataReadyP = 1'b0;
         if (newCostFunc) begin
            pulses++;
            pulseAt = k;
         end
         if (k == 1) check({tag, ".busy1"}, busy, 1);
         if (k == 4) check({tag, ".cost"}, costFunc, expCost);
         if (k == 5) check({tag, ".busy5"}, busy, 0);
`ifdef COST_STATS_EN
         statClear = (k == 4) && clrAtOut;
`endif
      end
      check({tag, ".pulses"}, pulses, 1);
      check({tag, ".pulseAt"}, pulseAt, 4);
   endtask

   initial begin
      int pulses;
      repeat (2) tick();
      check("rst.cost", costFunc, 0);
      check("rst.pulse", newCostFunc, 0);
      check("rst.busy", busy, 0);
      check("rst.overrun", overrun, 0);
`ifdef COST_STATS_EN
      check("rst.wrong", wrongCount, 0);
`endif
      reset = 1'b1;
      runVec("zero", 0, 1'b1, 512);
      runVec("pos5m1", 10240, 1'b1, 0);
      runVec("pos5m0", 10240, 1'b0, 2048);
      runVec("neg1m0", -2048, 1'b0, 128);
      runVec("half_m1", 1024, 1'b1, 288);
      runVec("minx_m1", -131072, 1'b1, 2048);
      // level held high must trigger once only
      tick();
      networkOutput = 18'sd1024;
      modelOutput = 1'b1;
      dataReadyP = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 10) dataReadyP = 1'b0;
         if (newCostFunc) pulses++;
      end
      check("hold.pulses", pulses, 1);
      check("hold.cost", costFunc, 288);
      check("hold.overrun", overrun, 0);
      // second rise while busy is dropped and flagged
      tick();
      networkOutput = -18'sd2048;
      modelOutput = 1'b0;
      dataReadyP = 1'b1;
      tick();
      dataReadyP = 1'b0;
      tick();
      networkOutput = 18'sd10240;
      modelOutput = 1'b1;
      dataReadyP = 1'b1;
      tick();
      dataReadyP = 1'b0;
      tick();
      check("ovr.pulse", newCostFunc, 1);
      check("ovr.cost", costFunc, 128);
      check("ovr.flag", overrun, 1);
      repeat (3) tick();
      check("ovr.sticky", overrun, 1);
      check("ovr.idle", busy, 0);
      // reset in the middle of a computation
      tick();
      networkOutput = '0;
      modelOutput = 1'b1;
      dataReadyP = 1'b1;
      tick();
      dataReadyP = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      check("mid.cost", costFunc, 0);
      check("mid.busy", busy, 0);
      check("mid.pulse", newCostFunc, 0);
      check("mid.overrun", overrun, 0);
      reset = 1'b1;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (newCostFunc) pulses++;
      end
      check("mid.nopulse", pulses, 0);
      runVec("fresh", 1024, 1'b1, 288);
`ifdef COST_STATS_EN
      statClear = 1'b1;
      tick();
      statClear = 1'b0;
      check("stat.clr", wrongCount, 0);
      runVec("stat.a", 10240, 1'b0, 2048);
      runVec("stat.b", -131072, 1'b1, 2048);
      runVec("stat.c", 0, 1'b0, 512);
      runVec("stat.d", 1024, 1'b1, 288);
      check("stat.count", wrongCount, 3);
      clrAtOut = 1'b1;
      runVec("stat.e", 10240, 1'b0, 2048);
      clrAtOut = 1'b0;
      check("stat.clrwins", wrongCount, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
